// File: rtl/set_assoc_data_cache_if.sv
// CPU load/store and data-memory signals of the 2-way data cache, bundled as one port.
interface set_assoc_data_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  cpu_re;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [CNT_WIDTH-1:0]  hit_count;
  logic [CNT_WIDTH-1:0]  miss_count;

  // cache side
  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
    output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata,
           hit_count, miss_count
  );

  // CPU + memory side
  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata,
           hit_count, miss_count
  );
endinterface

// File: rtl/set_assoc_data_cache.sv
// 2-way set-associative, write-through, no-write-allocate data cache, one word per
// line, LRU replacement, miss/write FSM with ready handshake and saturating
// hit/miss counters.
module set_assoc_data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SET_WIDTH  = 3,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  set_assoc_data_cache_if.slave  bus
);
  localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - 2;
  localparam int SETS      = 2 ** SET_WIDTH;
  localparam int NUM_WAYS  = 2;
  localparam int WA_WIDTH  = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_THRU} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0][NUM_WAYS-1:0] valid_q;
  logic [SETS-1:0]               lru_q;     // index of least-recently-used way
  logic [TAG_WIDTH-1:0]          tag_q  [SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0]         data_q [SETS][NUM_WAYS];

  // request captured at issue; CPU holds its inputs too, but memory sees these
  logic [WA_WIDTH-1:0]   waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

  // lookup uses the live CPU address in IDLE and the captured one while busy
  logic [WA_WIDTH-1:0]   lk_waddr;
  logic [SET_WIDTH-1:0]  lk_set;
  logic [TAG_WIDTH-1:0]  lk_tag;
  logic [NUM_WAYS-1:0]   hit_way;
  logic                  hit;
  logic                  hit_idx;
  logic                  fill_way;

  logic                  issue, fill, touch, wr_line, inc_hit, inc_miss;
  logic                  stall, req, mwe;
  logic [ADDR_WIDTH-1:0] maddr;
  logic [DATA_WIDTH-1:0] mwdata, rdata;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.cpu_addr[1:0];

  assign lk_waddr = (state_q == IDLE) ? bus.cpu_addr[ADDR_WIDTH-1:2] : waddr_q;
  assign lk_set   = lk_waddr[SET_WIDTH-1:0];
  assign lk_tag   = lk_waddr[WA_WIDTH-1:SET_WIDTH];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign hit_way[w] = valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag);
  end

  // tags are unique per set, so at most one way hits
  assign hit     = |hit_way;
  assign hit_idx = hit_way[1];

  // victim: invalid way 0, then invalid way 1, else the LRU way
  assign fill_way = !valid_q[lk_set][0] ? 1'b0 :
                    !valid_q[lk_set][1] ? 1'b1 : lru_q[lk_set];

  // next-state and handshake outputs
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    req      = 1'b0;
    mwe      = 1'b0;
    maddr    = {waddr_q, 2'b00};
    mwdata   = wdata_q;
    rdata    = '0;
    issue    = 1'b0;
    fill     = 1'b0;
    touch    = 1'b0;
    wr_line  = 1'b0;
    inc_hit  = 1'b0;
    inc_miss = 1'b0;
    case (state_q)
      IDLE: begin
        maddr  = {bus.cpu_addr[ADDR_WIDTH-1:2], 2'b00};
        mwdata = bus.cpu_wdata;
        if (bus.cpu_we) begin
          stall   = 1'b1;
          req     = 1'b1;
          mwe     = 1'b1;
          issue   = 1'b1;
          state_d = WRITE_THRU;
        end else if (bus.cpu_re) begin
          if (hit) begin
            rdata   = data_q[lk_set][hit_idx];
            touch   = 1'b1;
            inc_hit = 1'b1;
          end else begin
            stall   = 1'b1;
            req     = 1'b1;
            issue   = 1'b1;
            state_d = READ_MISS;
          end
        end
      end
      READ_MISS: begin
        req   = 1'b1;
        stall = !bus.mem_ready;
        if (bus.mem_ready) begin
          rdata    = bus.mem_rdata;
          fill     = 1'b1;
          inc_miss = 1'b1;
          state_d  = IDLE;
        end
      end
      WRITE_THRU: begin
        req   = 1'b1;
        mwe   = 1'b1;
        stall = !bus.mem_ready;
        if (bus.mem_ready) begin
          if (hit) begin
            touch   = 1'b1;
            wr_line = 1'b1;
            inc_hit = 1'b1;
          end else begin
            inc_miss = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // capture the memory request so it stays stable until mem_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (issue) begin
      waddr_q <= bus.cpu_addr[ADDR_WIDTH-1:2];
      wdata_q <= bus.cpu_wdata;
    end
  end

  // valid bits and LRU; the way just used becomes most recent
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else if (fill) begin
      valid_q[lk_set][fill_way] <= 1'b1;
      lru_q[lk_set]             <= ~fill_way;
    end else if (touch) begin
      lru_q[lk_set] <= ~hit_idx;
    end
  end

  // tag/data arrays; contents are don't-care while the valid bit is clear
  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      tag_q[lk_set][fill_way]  <= lk_tag;
      data_q[lk_set][fill_way] <= bus.mem_rdata;
    end else if (!rst && wr_line) begin
      data_q[lk_set][hit_idx] <= wdata_q;
    end
  end

  // saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (inc_hit && !(&hit_cnt_q))   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (inc_miss && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign bus.cpu_stall  = stall;
  assign bus.cpu_rdata  = rdata;
  assign bus.mem_req    = req;
  assign bus.mem_we     = mwe;
  assign bus.mem_addr   = maddr;
  assign bus.mem_wdata  = mwdata;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_set_assoc_data_cache.sv
// Bench for set_assoc_data_cache: directed scenarios plus random traffic, checked
// against a per-set recency-list model of the cache and a word-addressed memory.
module tb_set_assoc_data_cache;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int SW   = 3;
  localparam int CW   = 4;
  localparam int NSET = 2 ** SW;
  localparam int CMAX = 2 ** CW - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  set_assoc_data_cache_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus();

  set_assoc_data_cache #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SET_WIDTH(SW), .CNT_WIDTH(CW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  // model: per set a list of resident word addresses, most recent first (max 2)
  int unsigned   rec [NSET][$];
  logic [DW-1:0] cdat [int unsigned];
  logic [DW-1:0] mem  [int unsigned];
  int            m_hit, m_miss;

  function automatic void model_reset();
    for (int s = 0; s < NSET; s++) rec[s].delete();
    cdat.delete();
    m_hit  = 0;
    m_miss = 0;
  endfunction

  function automatic bit resident(int unsigned wa);
    int s = int'(wa % NSET);
    foreach (rec[s][i]) if (rec[s][i] == wa) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void make_recent(int unsigned wa);
    int s = int'(wa % NSET);
    for (int i = rec[s].size() - 1; i >= 0; i--) if (rec[s][i] == wa) rec[s].delete(i);
    rec[s].push_front(wa);
    if (rec[s].size() > 2) void'(rec[s].pop_back());
  endfunction

  function automatic logic [DW-1:0] mem_rd(int unsigned wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  function automatic int sat_inc(int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // One CPU access starting just after a negedge; returns whether it completed
  // without stalling. wait_c = busy cycles before mem_ready is raised.
  task automatic access(input logic re, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int wait_c, output logic obs_hit);
    int unsigned   wa = addr >> 2;
    bit            is_load = !we && re;
    bit            exp_hit = resident(wa);
    logic [DW-1:0] rd;
    bus.cpu_re = re; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    bus.mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (bus.cpu_stall !== !(is_load && exp_hit)) begin
      n_fail++;
      $display("FAIL stall_at_issue addr=%h: got %b want %b", addr, bus.cpu_stall, !(is_load && exp_hit));
    end
    obs_hit = !bus.cpu_stall;
    if (is_load && exp_hit) begin
      n_cmp++;
      if (bus.cpu_rdata !== cdat[wa] || bus.mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL load_hit addr=%h: got rdata %h req %b want %h req 0", addr, bus.cpu_rdata, bus.mem_req, cdat[wa]);
      end
      @(posedge clk);
      make_recent(wa);
      m_hit = sat_inc(m_hit);
    end else begin
      n_cmp++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== we || bus.mem_addr !== {addr[AW-1:2], 2'b00} ||
          (we && bus.mem_wdata !== wdata)) begin
        n_fail++;
        $display("FAIL issue addr=%h: got req %b we %b maddr %h wd %h want 1 %b %h %h", addr,
                 bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, we, {addr[AW-1:2], 2'b00}, wdata);
      end
      @(posedge clk);
      for (int i = 0; i < wait_c; i++) begin
        @(negedge clk); #1;
        n_cmp++;
        if (bus.cpu_stall !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_we !== we ||
            bus.mem_addr !== {addr[AW-1:2], 2'b00}) begin
          n_fail++;
          $display("FAIL busy_hold addr=%h: got stall %b req %b we %b maddr %h", addr,
                   bus.cpu_stall, bus.mem_req, bus.mem_we, bus.mem_addr);
        end
      end
      @(negedge clk);
      rd = is_load ? mem_rd(wa) : $urandom;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = rd;
      #1;
      n_cmp++;
      if (bus.cpu_stall !== 1'b0 || (is_load && bus.cpu_rdata !== rd)) begin
        n_fail++;
        $display("FAIL ready_cycle addr=%h: got stall %b rdata %h want 0 %h", addr, bus.cpu_stall, bus.cpu_rdata, rd);
      end
      @(posedge clk);
      if (is_load) begin
        make_recent(wa);
        cdat[wa] = rd;
        m_miss = sat_inc(m_miss);
      end else begin
        mem[wa] = wdata;
        if (exp_hit) begin
          cdat[wa] = wdata;
          make_recent(wa);
          m_hit = sat_inc(m_hit);
        end else begin
          m_miss = sat_inc(m_miss);
        end
      end
    end
    @(negedge clk);
    bus.cpu_re = 1'b0; bus.cpu_we = 1'b0; bus.mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (bus.hit_count !== CW'(m_hit) || bus.miss_count !== CW'(m_miss)) begin
      n_fail++;
      $display("FAIL counters addr=%h: got hit %0d miss %0d want %0d %0d", addr,
               bus.hit_count, bus.miss_count, m_hit, m_miss);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_re = 1'b0; bus.cpu_we = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (bus.cpu_stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 ||
        bus.cpu_rdata !== '0 || bus.hit_count !== '0 || bus.miss_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got stall %b req %b we %b rdata %h hit %0d miss %0d",
               bus.cpu_stall, bus.mem_req, bus.mem_we, bus.cpu_rdata, bus.hit_count, bus.miss_count);
    end
  endtask

  task automatic test_miss_then_hit();
    logic h;
    do_reset();
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    access(1, 0, 32'h100, 0, 1, h);
    n_cmp++;
    if (h !== 1'b0 || bus.miss_count !== 4'd1) begin
      n_fail++; $display("FAIL first_load_miss: got hit %b miss_count %0d want 0 1", h, bus.miss_count);
    end
    access(1, 0, 32'h100, 0, 0, h);
    n_cmp++;
    if (h !== 1'b1 || bus.hit_count !== 4'd1) begin
      n_fail++; $display("FAIL second_load_hit: got hit %b hit_count %0d want 1 1", h, bus.hit_count);
    end
  endtask

  task automatic test_lru();
    logic h;
    do_reset();
    access(1, 0, 32'h100, 0, 0, h);
    access(1, 0, 32'h200, 0, 2, h);
    access(1, 0, 32'h100, 0, 0, h);
    access(1, 0, 32'h300, 0, 1, h);
    access(1, 0, 32'h100, 0, 0, h);
    n_cmp++;
    if (h !== 1'b1) begin n_fail++; $display("FAIL lru_keep_recent: got hit %b want 1", h); end
    access(1, 0, 32'h200, 0, 0, h);
    n_cmp++;
    if (h !== 1'b0) begin n_fail++; $display("FAIL lru_evicted: got hit %b want 0", h); end
  endtask

  task automatic test_store();
    logic h;
    do_reset();
    access(1, 0, 32'h100, 0, 0, h);
    access(0, 1, 32'h100, 32'h55, 2, h);
    access(1, 0, 32'h100, 0, 0, h);
    n_cmp++;
    if (h !== 1'b1 || cdat[32'h100 >> 2] !== 32'h55) begin
      n_fail++; $display("FAIL store_hit_update: got hit %b want 1", h);
    end
    access(0, 1, 32'h400, 32'h1234, 1, h);
    access(1, 0, 32'h400, 0, 0, h);
    n_cmp++;
    if (h !== 1'b0) begin n_fail++; $display("FAIL store_no_allocate: got hit %b want 0", h); end
  endtask

  task automatic test_both_and_abort();
    logic h;
    do_reset();
    access(1, 1, 32'h104, 32'hA5A5A5A5, 0, h);   // store path checked inside (mem_we=1)
    access(1, 0, 32'h108, 0, 0, h);
    @(negedge clk);
    bus.cpu_re = 1'b1; bus.cpu_addr = 32'h208;
    @(negedge clk);                               // now in READ_MISS
    rst = 1'b1; bus.cpu_re = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.hit_count !== '0 || bus.miss_count !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: got req %b stall %b hit %0d miss %0d", bus.mem_req, bus.cpu_stall,
               bus.hit_count, bus.miss_count);
    end
    model_reset();
    rst = 1'b0;
    access(1, 0, 32'h108, 0, 0, h);
    n_cmp++;
    if (h !== 1'b0) begin n_fail++; $display("FAIL reset_invalidates: got hit %b want 0", h); end
  endtask

  task automatic test_saturate();
    logic h;
    do_reset();
    access(1, 0, 32'h100, 0, 0, h);
    for (int i = 0; i < CMAX + 3; i++) access(1, 0, 32'h100, 0, 0, h);
    n_cmp++;
    if (bus.hit_count !== 4'd15) begin
      n_fail++; $display("FAIL hit_saturate: got %0d want 15", bus.hit_count);
    end
  endtask

  task automatic test_random();
    logic          h;
    int unsigned   r;
    logic [AW-1:0] a;
    do_reset();
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 5);
      a = AW'(($urandom_range(0, 3) << (SW + 2)) | ($urandom_range(0, NSET - 1) << 2) | $urandom_range(0, 3));
      if (r == 5) begin
        // idle cycle with a stray mem_ready, which must be ignored
        bus.mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.cpu_stall !== 1'b0 || bus.mem_req !== 1'b0) begin
          n_fail++; $display("FAIL idle_quiet: got stall %b req %b", bus.cpu_stall, bus.mem_req);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
      end else begin
        access(r != 3, r >= 3, a, $urandom, $urandom_range(0, 3), h);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cpu_re = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    model_reset();
    test_reset();
    test_miss_then_hit();
    test_lru();
    test_store();
    test_both_and_abort();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
